// File: rtl/audio_pkg.sv
// Shared types and constants for the audio stream controller.
package audio_pkg;
  localparam int AUDIO_FIFO_DEPTH = 64;

  typedef struct packed {
    logic signed [15:0] left;
    logic signed [15:0] right;
  } sample_pair_t;

  typedef enum logic {GRANT_CPU = 1'b0, GRANT_DMA = 1'b1} grant_t;
endpackage

// File: rtl/audio_pair_fifo.sv
// Synchronous FIFO of stereo pairs; occupancy kept as a separate counter so full is level == DEPTH.
module audio_pair_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = AUDIO_FIFO_DEPTH,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  sample_pair_t push_data,
  input  logic         pop,
  output sample_pair_t head,
  output logic [LW-1:0] level,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  sample_pair_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
endmodule

// File: rtl/audio_stream_ctrl.sv
// Two-source (CPU/DMA) round-robin push into a pair FIFO, drained by I2S sample strobes.
module audio_stream_ctrl
  import audio_pkg::*;
#(
  parameter int DEPTH = AUDIO_FIFO_DEPTH,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cpu_valid,
  output logic               cpu_ready,
  input  logic signed [15:0] cpu_left,
  input  logic signed [15:0] cpu_right,
  input  logic               dma_valid,
  output logic               dma_ready,
  input  logic signed [15:0] dma_left,
  input  logic signed [15:0] dma_right,
  input  logic               cfg_enable,
  input  logic               cfg_mute,
  input  logic [LW-1:0]      cfg_low_water,
  input  logic               clear_underrun,
  input  logic               sample_strobe,
  output logic signed [15:0] sample_left,
  output logic signed [15:0] sample_right,
  output logic [LW-1:0]      level,
  output logic               irq_low,
  output logic [15:0]        underrun_count
);
  grant_t       last_grant;
  logic         accept_ok, cpu_grant, dma_grant;
  logic         push, pop, underrun, full, empty;
  sample_pair_t push_data, head;
  logic [LW-1:0] level_next;

  // On contention the source that did not win the last completed push is granted.
  assign cpu_grant = cpu_valid & (~dma_valid | (last_grant == GRANT_DMA));
  assign dma_grant = dma_valid & (~cpu_valid | (last_grant == GRANT_CPU));
  assign accept_ok = cfg_enable & ~full & ~reset;
  assign cpu_ready = accept_ok & cpu_grant;
  assign dma_ready = accept_ok & dma_grant;
  assign push      = cpu_ready | dma_ready;

  always_comb begin
    push_data = '0;
    if (cpu_ready) begin
      push_data.left  = cpu_left;
      push_data.right = cpu_right;
    end else begin
      push_data.left  = dma_left;
      push_data.right = dma_right;
    end
  end

  // Empty is sampled before this cycle's push, so a coincident push never rescues the strobe.
  assign pop        = sample_strobe & cfg_enable & ~empty;
  assign underrun   = sample_strobe & cfg_enable & empty;
  assign level_next = cfg_enable ? (level + LW'(push) - LW'(pop)) : '0;

  audio_pair_fifo #(.DEPTH(DEPTH), .LW(LW)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (~cfg_enable),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant     <= GRANT_DMA;
      sample_left    <= '0;
      sample_right   <= '0;
      irq_low        <= 1'b0;
      underrun_count <= '0;
    end else begin
      if (push) last_grant <= cpu_ready ? GRANT_CPU : GRANT_DMA;

      if (!cfg_enable || underrun) begin
        sample_left  <= '0;
        sample_right <= '0;
      end else if (pop) begin
        sample_left  <= cfg_mute ? '0 : head.left;
        sample_right <= cfg_mute ? '0 : head.right;
      end

      if (clear_underrun)
        underrun_count <= '0;
      else if (underrun && underrun_count != 16'hFFFF)
        underrun_count <= underrun_count + 16'd1;

      irq_low <= cfg_enable & (level_next < cfg_low_water);
    end
  end
endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Bench for audio_stream_ctrl: directed vector table, scenario sequences, and random traffic vs a queue model.
module tb_audio_stream_ctrl;
  localparam int DEPTH = 64;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cpu_valid = 0, dma_valid = 0;
  logic cpu_ready, dma_ready;
  logic [15:0] cpu_left = 0, cpu_right = 0, dma_left = 0, dma_right = 0;
  logic cfg_enable = 0, cfg_mute = 0, clear_underrun = 0, sample_strobe = 0;
  logic [LW-1:0] cfg_low_water = 0;
  logic [15:0] sample_left, sample_right, underrun_count;
  logic [LW-1:0] level;
  logic irq_low;

  int n_tests = 0;
  int n_fail  = 0;

  audio_stream_ctrl #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_left(cpu_left), .cpu_right(cpu_right),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_left(dma_left), .dma_right(dma_right),
    .cfg_enable(cfg_enable), .cfg_mute(cfg_mute), .cfg_low_water(cfg_low_water),
    .clear_underrun(clear_underrun), .sample_strobe(sample_strobe),
    .sample_left(sample_left), .sample_right(sample_right),
    .level(level), .irq_low(irq_low), .underrun_count(underrun_count)
  );

  always #4 clock = ~clock;

  // Reference model state
  logic [31:0] m_q[$];
  bit          m_last_cpu = 0;
  logic [15:0] m_left = 0, m_right = 0;
  int          m_urc = 0;
  bit          m_irq = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: check readys against the model, advance the model, then check registered outputs.
  task automatic step();
    bit cpu_wins, e_cr, e_dr, full;
    logic [31:0] hd;
    #1;
    e_cr = 0; e_dr = 0;
    if (!reset) begin
      full = (m_q.size() == DEPTH);
      cpu_wins = (cpu_valid && dma_valid) ? !m_last_cpu : cpu_valid;
      e_cr = cfg_enable && !full && cpu_valid && cpu_wins;
      e_dr = cfg_enable && !full && dma_valid && !cpu_wins;
    end
    chk("cpu_ready", cpu_ready, e_cr);
    chk("dma_ready", dma_ready, e_dr);
    if (reset) begin
      m_q.delete(); m_last_cpu = 0; m_left = 0; m_right = 0; m_urc = 0; m_irq = 0;
    end else if (!cfg_enable) begin
      m_q.delete(); m_left = 0; m_right = 0; m_irq = 0;
      if (clear_underrun) m_urc = 0;
    end else begin
      if (sample_strobe && m_q.size() > 0) begin
        hd = m_q.pop_front();
        m_left  = cfg_mute ? 16'h0 : hd[31:16];
        m_right = cfg_mute ? 16'h0 : hd[15:0];
      end else if (sample_strobe) begin
        m_left = 0; m_right = 0;
        if (m_urc < 65535) m_urc++;
      end
      if (clear_underrun) m_urc = 0;
      if (e_cr) begin m_q.push_back({cpu_left, cpu_right}); m_last_cpu = 1; end
      else if (e_dr) begin m_q.push_back({dma_left, dma_right}); m_last_cpu = 0; end
      m_irq = (m_q.size() < int'(cfg_low_water));
    end
    @(posedge clock);
    #1;
    chk("level", level, m_q.size());
    chk("sample_left", sample_left, m_left);
    chk("sample_right", sample_right, m_right);
    chk("underrun_count", underrun_count, m_urc);
    chk("irq_low", irq_low, m_irq);
  endtask

  task automatic idle();
    cpu_valid = 0; dma_valid = 0; sample_strobe = 0; clear_underrun = 0;
  endtask

  typedef struct {
    bit rst, en, cv, dv, stb, clr;
    logic [15:0] cl, cr, dl, dr;
    int lvl;
    logic [15:0] el, er;
    int urc;
  } vec_t;

  function automatic vec_t v(input bit rst, en, cv, input logic [15:0] cl, cr,
                             input bit dv, input logic [15:0] dl, dr, input bit stb, clr,
                             input int lvl, input logic [15:0] el, er, input int urc);
    vec_t r;
    r.rst = rst; r.en = en; r.cv = cv; r.cl = cl; r.cr = cr; r.dv = dv; r.dl = dl; r.dr = dr;
    r.stb = stb; r.clr = clr; r.lvl = lvl; r.el = el; r.er = er; r.urc = urc;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    // rst en  cv cl cr            dv dl dr            stb clr lvl el er urc
    tbl.push_back(v(1,0, 0,0,0,             0,0,0,             0,0, 0, 0,0, 0));
    tbl.push_back(v(0,1, 1,16'hC001,16'h1C01, 1,16'hD001,16'h1D01, 0,0, 1, 0,0, 0));
    tbl.push_back(v(0,1, 1,16'hC002,16'h1C02, 1,16'hD002,16'h1D02, 0,0, 2, 0,0, 0));
    tbl.push_back(v(0,1, 1,16'hC003,16'h1C03, 1,16'hD003,16'h1D03, 0,0, 3, 0,0, 0));
    tbl.push_back(v(0,1, 1,16'hC004,16'h1C04, 1,16'hD004,16'h1D04, 0,0, 4, 0,0, 0));
    tbl.push_back(v(0,1, 0,0,0, 0,0,0, 1,0, 3, 16'hC001,16'h1C01, 0));
    tbl.push_back(v(0,1, 0,0,0, 0,0,0, 1,0, 2, 16'hD002,16'h1D02, 0));
    tbl.push_back(v(0,1, 0,0,0, 0,0,0, 1,0, 1, 16'hC003,16'h1C03, 0));
    tbl.push_back(v(0,1, 0,0,0, 0,0,0, 1,0, 0, 16'hD004,16'h1D04, 0));
    tbl.push_back(v(0,1, 0,0,0, 0,0,0, 1,0, 0, 0,0, 1));
    tbl.push_back(v(0,1, 0,0,0, 0,0,0, 1,0, 0, 0,0, 2));
    tbl.push_back(v(0,1, 0,0,0, 0,0,0, 1,0, 0, 0,0, 3));
    tbl.push_back(v(0,1, 0,0,0, 0,0,0, 1,1, 0, 0,0, 0));
    tbl.push_back(v(0,1, 1,16'h1234,16'hABCD, 0,0,0, 0,0, 1, 0,0, 0));
    tbl.push_back(v(0,1, 1,16'h0001,16'hFFFF, 0,0,0, 0,0, 2, 0,0, 0));
    tbl.push_back(v(0,1, 0,0,0, 0,0,0, 1,0, 1, 16'h1234,16'hABCD, 0));
    tbl.push_back(v(0,1, 0,0,0, 0,0,0, 1,0, 0, 16'h0001,16'hFFFF, 0));
    tbl.push_back(v(0,1, 1,16'h5555,16'h6666, 0,0,0, 1,0, 1, 0,0, 1));
    tbl.push_back(v(0,1, 0,0,0, 0,0,0, 1,0, 0, 16'h5555,16'h6666, 1));

    foreach (tbl[i]) begin
      reset = tbl[i].rst; cfg_enable = tbl[i].en;
      cpu_valid = tbl[i].cv; cpu_left = tbl[i].cl; cpu_right = tbl[i].cr;
      dma_valid = tbl[i].dv; dma_left = tbl[i].dl; dma_right = tbl[i].dr;
      sample_strobe = tbl[i].stb; clear_underrun = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("tbl%0d_left", i), sample_left, tbl[i].el);
      chk($sformatf("tbl%0d_right", i), sample_right, tbl[i].er);
      chk($sformatf("tbl%0d_urc", i), underrun_count, tbl[i].urc);
    end
    idle();

    // Fill to DEPTH, then a strobe with both sources pushing: pop happens, push does not.
    cpu_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_left = 16'($urandom); cpu_right = 16'($urandom);
      step();
    end
    chk("fill_level", level, DEPTH);
    dma_valid = 1;
    #1;
    chk("full_cpu_ready", cpu_ready, 0);
    chk("full_dma_ready", dma_ready, 0);
    sample_strobe = 1;
    step();
    chk("full_pop_level", level, DEPTH - 1);
    idle();
    cfg_enable = 0; step();
    cfg_enable = 1; step();

    // Mute and low water.
    cfg_low_water = 8;
    cpu_valid = 1;
    for (int i = 0; i < 10; i++) begin
      cpu_left = 16'(i + 100); cpu_right = 16'(i + 200);
      step();
    end
    idle();
    chk("lw_level10", level, 10);
    chk("lw_irq_at10", irq_low, 0);
    cfg_mute = 1; sample_strobe = 1;
    step(); step();
    chk("lw_irq_at8", irq_low, 0);
    step();
    chk("lw_level7", level, 7);
    chk("lw_irq_at7", irq_low, 1);
    chk("mute_left", sample_left, 0);
    chk("mute_right", sample_right, 0);
    idle(); cfg_mute = 0;

    // Disable flush from level 20.
    cpu_valid = 1;
    for (int i = 0; i < 13; i++) begin
      cpu_left = 16'($urandom); cpu_right = 16'($urandom);
      step();
    end
    chk("dis_level20", level, 20);
    cfg_enable = 0; dma_valid = 1;
    #1;
    chk("dis_cpu_ready", cpu_ready, 0);
    chk("dis_dma_ready", dma_ready, 0);
    step();
    chk("dis_level0", level, 0);
    chk("dis_irq", irq_low, 0);
    sample_strobe = 1;
    step();
    chk("dis_strobe_urc", underrun_count, 1);
    chk("dis_out_left", sample_left, 0);
    idle();
    cfg_enable = 1;
    #1;
    chk("reen_level", level, 0);
    cpu_valid = 1; cpu_left = 16'h7777; cpu_right = 16'h8888;
    #1;
    chk("reen_cpu_ready", cpu_ready, 1);
    step();
    chk("reen_level1", level, 1);

    // Mid-stream reset.
    reset = 1;
    #1;
    chk("rst_cpu_ready", cpu_ready, 0);
    step();
    chk("rst_level", level, 0);
    reset = 0; idle();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(0, 199) == 0);
      cfg_enable     = ($urandom_range(0, 29) != 0);
      cfg_mute       = ($urandom_range(0, 9) == 0);
      cfg_low_water  = LW'($urandom_range(0, DEPTH));
      cpu_valid      = $urandom_range(0, 1);
      dma_valid      = $urandom_range(0, 1);
      cpu_left = 16'($urandom); cpu_right = 16'($urandom);
      dma_left = 16'($urandom); dma_right = 16'($urandom);
      sample_strobe  = ($urandom_range(0, 9) < 4);
      clear_underrun = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
